// File: rtl/pipe_32_pkg.sv
// Shared types and constants for the 32-bit pipeline memory responder.
// Holds the responder FSM states, the requesting-port ids, the default
// geometry and the largest supported number of wait states.
package pipe_32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int WAIT_CYC_MAX = 7;

endpackage

// File: rtl/mem_arbiter_32.sv
// Grant selection between the instruction-fetch and data ports.
// Grants are only issued while the responder is idle, out of reset and no
// backdoor load is taking the array this cycle.
// Build option RR_ARB_EN: round-robin tie-break with a pointer register;
// otherwise fixed priority, data port over fetch port.
module mem_arbiter_32
    import pipe_32_pkg::*;
(
`ifdef RR_ARB_EN
    input  logic clk1,
`endif
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    input  logic idle,
    input  logic ld_en,
    output logic if_gnt,
    output logic d_gnt
);

    logic can_grant;

    assign can_grant = idle & ~ld_en & rst_n;

`ifdef RR_ARB_EN
    port_id_t prio_port;

    // Hand priority to the port that was not served by the most recent grant
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            prio_port <= PORT_D;
        end else if (if_gnt) begin
            prio_port <= PORT_D;
        end else if (d_gnt) begin
            prio_port <= PORT_IF;
        end
    end

    // Grant a lone requester directly; break ties toward the favoured port
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (can_grant) begin
            if (if_req && d_req) begin
                if (prio_port == PORT_D) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end
`else
    // Fixed priority: the data port always wins a tie
    always_comb begin
        d_gnt  = can_grant & d_req;
        if_gnt = can_grant & if_req & ~d_req;
    end
`endif

endmodule

// File: rtl/mem_responder_32.sv
// Word-addressed memory responder for the 32-bit pipeline.
// Serves one fetch or data request at a time through IDLE -> WAIT -> RESP,
// inserting WAIT_CYC wait states, and answers with a one-cycle rvalid pulse
// on the owning port. A backdoor load port writes the array while idle.
// Build option RR_ARB_EN selects round-robin arbitration in mem_arbiter_32.
module mem_responder_32
    import pipe_32_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_CYC = 1
)(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    if (WAIT_CYC < 0 || WAIT_CYC > WAIT_CYC_MAX) begin : g_bad_wait_cyc
        $error("mem_responder_32: WAIT_CYC out of range 0..7");
    end

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    mem_state_t        state;
    logic [2:0]        wait_cnt;
    port_id_t          cap_port;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [DATA_W-1:0] cap_wdata;

    logic              idle;
    logic              grant_any;
    port_id_t          grant_port;
    logic [ADDR_W-1:0] grant_addr;
    logic              grant_we;

    logic              resp_next;
    port_id_t          resp_port;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_we;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idle = (state == IDLE);
    assign busy = ~idle;

    mem_arbiter_32 u_arb (
`ifdef RR_ARB_EN
        .clk1   (clk1),
`endif
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .idle   (idle),
        .ld_en  (ld_en),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    // Select the request being accepted this cycle (at most one grant is high)
    always_comb begin
        grant_any  = if_gnt | d_gnt;
        grant_port = d_gnt ? PORT_D : PORT_IF;
        grant_addr = d_gnt ? d_addr : if_addr;
        grant_we   = d_gnt & d_we;
    end

    // Detect the edge that enters RESP and which transaction it belongs to, so
    // rvalid and rdata are registered and visible throughout the RESP cycle
    always_comb begin
        resp_next = 1'b0;
        resp_port = cap_port;
        resp_addr = cap_addr;
        resp_we   = cap_we;
        if (idle) begin
            resp_next = grant_any && (WAIT_CYC == 0);
            resp_port = grant_port;
            resp_addr = grant_addr;
            resp_we   = grant_we;
        end else if (state == WAIT) begin
            resp_next = (wait_cnt == WAIT_LAST);
        end
    end

    // Array write port: stores commit in RESP, backdoor loads only while idle
    always_comb begin
        mem_we    = rst_n & ((state == RESP && cap_we) || (idle && ld_en));
        mem_waddr = idle ? ld_addr : cap_addr;
        mem_wdata = idle ? ld_data : cap_wdata;
    end

    // Memory array, deliberately not reset so preloaded contents survive
    always_ff @(posedge clk1) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Responder FSM: capture on grant, count wait states, pulse the response
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            cap_port  <= PORT_IF;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (resp_next) begin
                if (resp_port == PORT_IF) begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= resp_we ? '0 : mem[resp_addr];
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= resp_we ? '0 : mem[resp_addr];
                end
            end
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cap_port  <= grant_port;
                        cap_addr  <= grant_addr;
                        cap_we    <= grant_we;
                        cap_wdata <= d_wdata;
                        wait_cnt  <= 3'd0;
                        state     <= (WAIT_CYC == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    wait_cnt <= 3'd0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder_32.sv
// Directed self-checking bench for mem_responder_32.
// Main instance uses WAIT_CYC=1; two extra instances (WAIT_CYC=0 and 7) share
// one stimulus set to check wait-state latency and busy.
module tb_mem_responder_32;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk1 = 1'b0;
    logic rst_n;

    always #5 clk1 = ~clk1;

    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          ld_en, busy;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic          w_if_req, w_d_req, w_d_we, w_ld_en;
    logic [AW-1:0] w_if_addr, w_d_addr, w_ld_addr;
    logic [DW-1:0] w_d_wdata, w_ld_data;

    logic          z_if_gnt, z_if_rvalid, z_d_gnt, z_d_rvalid, z_busy;
    logic [DW-1:0] z_if_rdata, z_d_rdata;
    logic          s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_busy;
    logic [DW-1:0] s_if_rdata, s_d_rdata;

    int vectors     = 0;
    int miscompares = 0;

    mem_responder_32 #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
    );

    mem_responder_32 #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(0)) dut_w0 (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(w_if_req), .if_addr(w_if_addr), .if_gnt(z_if_gnt),
        .if_rvalid(z_if_rvalid), .if_rdata(z_if_rdata),
        .d_req(w_d_req), .d_we(w_d_we), .d_addr(w_d_addr), .d_wdata(w_d_wdata),
        .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
        .ld_en(w_ld_en), .ld_addr(w_ld_addr), .ld_data(w_ld_data), .busy(z_busy)
    );

    mem_responder_32 #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(7)) dut_w7 (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(w_if_req), .if_addr(w_if_addr), .if_gnt(s_if_gnt),
        .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
        .d_req(w_d_req), .d_we(w_d_we), .d_addr(w_d_addr), .d_wdata(w_d_wdata),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .ld_en(w_ld_en), .ld_addr(w_ld_addr), .ld_data(w_ld_data), .busy(s_busy)
    );

    // Inputs are driven 1 time unit after the rising edge, sampled 1 unit later
    task automatic next_cycle();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Drive one data-port transaction; report grant wait, latency and rdata
    task automatic d_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int gnt_wait,
                         output int lat, output logic [DW-1:0] rdata,
                         output logic other);
        next_cycle();
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        gnt_wait = 0;
        #1;
        while (d_gnt !== 1'b1 && gnt_wait < 20) begin
            next_cycle(); gnt_wait++; #1;
        end
        next_cycle();
        d_req = 1'b0; d_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
        lat = 1; other = 1'b0;
        #1;
        while (d_rvalid !== 1'b1 && lat < 20) begin
            if (if_rvalid === 1'b1) other = 1'b1;
            next_cycle(); lat++; #1;
        end
        if (if_rvalid === 1'b1) other = 1'b1;
        rdata = d_rdata;
    endtask

    // Drive one fetch-port transaction; report grant wait, latency and rdata
    task automatic if_txn(input logic [AW-1:0] addr, output int gnt_wait,
                          output int lat, output logic [DW-1:0] rdata,
                          output logic other);
        next_cycle();
        if_req = 1'b1; if_addr = addr;
        gnt_wait = 0;
        #1;
        while (if_gnt !== 1'b1 && gnt_wait < 20) begin
            next_cycle(); gnt_wait++; #1;
        end
        next_cycle();
        if_req = 1'b0; if_addr = ~addr;
        lat = 1; other = 1'b0;
        #1;
        while (if_rvalid !== 1'b1 && lat < 20) begin
            if (d_rvalid === 1'b1) other = 1'b1;
            next_cycle(); lat++; #1;
        end
        if (d_rvalid === 1'b1) other = 1'b1;
        rdata = if_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        next_cycle();
        if_req = 1'b1; d_req = 1'b1; w_d_req = 1'b1;
        #1;
        vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_if_gnt: got %b expected 0", if_gnt); end
        vectors++; if (d_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_d_gnt: got %b expected 0", d_gnt); end
        vectors++; if (if_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_if_rvalid: got %b expected 0", if_rvalid); end
        vectors++; if (d_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_d_rvalid: got %b expected 0", d_rvalid); end
        vectors++; if (if_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_if_rdata: got %h expected 0", if_rdata); end
        vectors++; if (d_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_d_rdata: got %h expected 0", d_rdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (s_d_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_w7_d_gnt: got %b expected 0", s_d_gnt); end
        next_cycle();
        if_req = 1'b0; d_req = 1'b0; w_d_req = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_backdoor();
        int gw, lat;
        logic [DW-1:0] rd;
        logic other;
        next_cycle();
        ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'h2800000A;
        next_cycle();
        ld_addr = 10'd9; ld_data = 32'h00000055;
        next_cycle();
        ld_addr = 10'd3; ld_data = 32'h00000033;
        next_cycle();
        ld_en = 1'b0;
        if_txn(10'd5, gw, lat, rd, other);
        vectors++; if (gw !== 0) begin miscompares++; $display("[TB] FAIL bd_gnt_wait: got %0d expected 0", gw); end
        vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL bd_latency: got %0d expected 2", lat); end
        vectors++; if (rd !== 32'h2800000A) begin miscompares++; $display("[TB] FAIL bd_if_rdata: got %h expected 2800000a", rd); end
        vectors++; if (other !== 1'b0) begin miscompares++; $display("[TB] FAIL bd_d_pulse: got %b expected 0", other); end
    endtask

    task automatic test_store_load();
        int gw, lat;
        logic [DW-1:0] rd;
        logic other;
        d_txn(1'b1, 10'd20, 32'hDEADBEEF, gw, lat, rd, other);
        vectors++; if (gw !== 0) begin miscompares++; $display("[TB] FAIL st_gnt_wait: got %0d expected 0", gw); end
        vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL st_latency: got %0d expected 2", lat); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL st_ack_rdata: got %h expected 0", rd); end
        vectors++; if (other !== 1'b0) begin miscompares++; $display("[TB] FAIL st_if_pulse: got %b expected 0", other); end
        d_txn(1'b0, 10'd20, 32'h0, gw, lat, rd, other);
        vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL ld_latency: got %0d expected 2", lat); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL ld_rdata: got %h expected deadbeef", rd); end
        vectors++; if (other !== 1'b0) begin miscompares++; $display("[TB] FAIL ld_if_pulse: got %b expected 0", other); end
        vectors++; if (if_rdata !== 32'h2800000A) begin miscompares++; $display("[TB] FAIL if_rdata_hold: got %h expected 2800000a", if_rdata); end
    endtask

    task automatic test_contention();
        do_reset();
        next_cycle();
        if_req = 1'b1; if_addr = 10'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        #1;
        vectors++; if (d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL ct_d_gnt: got %b expected 1", d_gnt); end
        vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL ct_if_gnt_n: got %b expected 0", if_gnt); end
        next_cycle();
        d_req = 1'b0;
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ct_busy_wait: got %b expected 1", busy); end
        vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL ct_if_gnt_n1: got %b expected 0", if_gnt); end
        next_cycle();
        #1;
        vectors++; if (d_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL ct_d_rvalid: got %b expected 1", d_rvalid); end
        vectors++; if (d_rdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL ct_d_rdata: got %h expected deadbeef", d_rdata); end
        vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL ct_if_gnt_n2: got %b expected 0", if_gnt); end
        next_cycle();
        #1;
        vectors++; if (if_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL ct_if_gnt_n3: got %b expected 1", if_gnt); end
        vectors++; if (d_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL ct_d_rvalid_off: got %b expected 0", d_rvalid); end
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        #1;
        vectors++; if (if_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL ct_if_rvalid: got %b expected 1", if_rvalid); end
        vectors++; if (if_rdata !== 32'h2800000A) begin miscompares++; $display("[TB] FAIL ct_if_rdata: got %h expected 2800000a", if_rdata); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        next_cycle();
        if_req = 1'b1; if_addr = 10'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        #1;
        vectors++; if (d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL bb_first_d_gnt: got %b expected 1", d_gnt); end
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
`ifdef RR_ARB_EN
        vectors++; if (if_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL bb_second_if_gnt: got %b expected 1", if_gnt); end
        vectors++; if (d_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL bb_second_d_gnt: got %b expected 0", d_gnt); end
`else
        vectors++; if (d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL bb_second_d_gnt: got %b expected 1", d_gnt); end
        vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL bb_second_if_gnt: got %b expected 0", if_gnt); end
`endif
        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bb_drained: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_store();
        int gw, lat;
        logic [DW-1:0] rd;
        logic other;
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wdata = 32'h00001234;
        #1;
        vectors++; if (d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_gnt: got %b expected 1", d_gnt); end
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_busy_wait: got %b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        d_req = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy_rst: got %b expected 0", busy); end
        vectors++; if (d_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_gnt_in_rst: got %b expected 0", d_gnt); end
        next_cycle();
        #1;
        vectors++; if (d_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_no_rvalid: got %b expected 0", d_rvalid); end
        d_req = 1'b0;
        rst_n = 1'b1;
        d_txn(1'b0, 10'd9, 32'h0, gw, lat, rd, other);
        vectors++; if (rd !== 32'h00000055) begin miscompares++; $display("[TB] FAIL rm_reload: got %h expected 00000055", rd); end
    endtask

    task automatic test_ld_en();
        int gw, lat;
        logic [DW-1:0] rd;
        logic other;
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd3;
        #1;
        vectors++; if (d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL lw_gnt: got %b expected 1", d_gnt); end
        next_cycle();
        d_req = 1'b0;
        ld_en = 1'b1; ld_addr = 10'd3; ld_data = 32'h00000BAD;
        next_cycle();
        ld_en = 1'b0;
        #1;
        vectors++; if (d_rdata !== 32'h00000033) begin miscompares++; $display("[TB] FAIL lw_rdata: got %h expected 00000033", d_rdata); end
        d_txn(1'b0, 10'd3, 32'h0, gw, lat, rd, other);
        vectors++; if (rd !== 32'h00000033) begin miscompares++; $display("[TB] FAIL lw_retained: got %h expected 00000033", rd); end
        next_cycle();
        ld_en = 1'b1; ld_addr = 10'd7; ld_data = 32'h00000077;
        if_req = 1'b1; if_addr = 10'd7;
        #1;
        vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL li_gnt_suppressed: got %b expected 0", if_gnt); end
        next_cycle();
        ld_en = 1'b0;
        #1;
        vectors++; if (if_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL li_gnt_next: got %b expected 1", if_gnt); end
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        #1;
        vectors++; if (if_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL li_rvalid: got %b expected 1", if_rvalid); end
        vectors++; if (if_rdata !== 32'h00000077) begin miscompares++; $display("[TB] FAIL li_rdata: got %h expected 00000077", if_rdata); end
    endtask

    task automatic test_wait_states();
        logic exp_z, exp_s, exp_sb;
        next_cycle();
        w_ld_en = 1'b1; w_ld_addr = 10'd5; w_ld_data = 32'hA5A50005;
        next_cycle();
        w_ld_en = 1'b0;
        w_d_req = 1'b1; w_d_we = 1'b0; w_d_addr = 10'd5;
        #1;
        vectors++; if (z_d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL ws0_gnt: got %b expected 1", z_d_gnt); end
        vectors++; if (s_d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL ws7_gnt: got %b expected 1", s_d_gnt); end
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            w_d_req = 1'b0;
            #1;
            exp_z  = (k == 1);
            exp_s  = (k == 8);
            exp_sb = (k <= 8);
            vectors++; if (z_d_rvalid !== exp_z) begin miscompares++; $display("[TB] FAIL ws0_rvalid@%0d: got %b expected %b", k, z_d_rvalid, exp_z); end
            vectors++; if (z_busy !== exp_z) begin miscompares++; $display("[TB] FAIL ws0_busy@%0d: got %b expected %b", k, z_busy, exp_z); end
            vectors++; if (s_d_rvalid !== exp_s) begin miscompares++; $display("[TB] FAIL ws7_rvalid@%0d: got %b expected %b", k, s_d_rvalid, exp_s); end
            vectors++; if (s_busy !== exp_sb) begin miscompares++; $display("[TB] FAIL ws7_busy@%0d: got %b expected %b", k, s_busy, exp_sb); end
            if (k == 1) begin
                vectors++; if (z_d_rdata !== 32'hA5A50005) begin miscompares++; $display("[TB] FAIL ws0_rdata: got %h expected a5a50005", z_d_rdata); end
            end
            if (k == 8) begin
                vectors++; if (s_d_rdata !== 32'hA5A50005) begin miscompares++; $display("[TB] FAIL ws7_rdata: got %h expected a5a50005", s_d_rdata); end
            end
        end
    endtask

    // Hard stop in case the sequence itself ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run every scenario in order, then print the summary
    initial begin
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        w_if_req = 1'b0; w_if_addr = '0;
        w_d_req = 1'b0; w_d_we = 1'b0; w_d_addr = '0; w_d_wdata = '0;
        w_ld_en = 1'b0; w_ld_addr = '0; w_ld_data = '0;
        test_reset();
        test_backdoor();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_mid_store();
        test_ld_en();
        test_wait_states();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder_32.md
Name: mem_responder_32

Overview:
- Word-addressed 1024x32 memory responder serving the 32-bit pipeline through two request ports: instruction fetch (IF) and data load/store (D).
- The pipeline side is the initiator. This block grants one request at a time and applies configurable wait states.
- It returns read data or a write acknowledge through a one-cycle valid pulse.
- A backdoor load port preloads programs and data before the pipeline starts.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W.
- DATA_W, 32, word width.
- WAIT_CYC, 1, wait states between grant and response; legal range 0..7.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; load data valid, or store committed.
- d_rdata  out  DATA_W  load data; 0 on store ack.
- ld_en  in  1  backdoor write strobe.
- ld_addr  in  ADDR_W  backdoor address.
- ld_data  in  DATA_W  backdoor data.
- busy  out  1  transaction in flight.

Behaviour:
- Clock and reset: one clock (clk1); reset rst_n is asynchronous, active-low.
- Reset values: if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, busy=0, FSM=IDLE, wait counter=0, round-robin pointer=D.
  - if_gnt/d_gnt are combinational and forced to 0 while rst_n=0.
  - Memory array is not reset.
- FSM states IDLE, WAIT, RESP.
  - IDLE: at most one grant per cycle. Grant captures port id, address, we, wdata into registers.
    - Next state: WAIT if WAIT_CYC>0, else RESP.
  - WAIT: counter counts 1..WAIT_CYC; at WAIT_CYC -> RESP. No grants.
  - RESP: read or write the array using the captured registers.
    - Pulse the owning port's rvalid with rdata (store: rdata=0); the other port's rdata holds its value.
    - Next state IDLE. No grant in RESP.
- Latency: grant cycle N -> rvalid at cycle N+WAIT_CYC+1. Minimum issue interval WAIT_CYC+2 cycles.
- busy=1 in WAIT and RESP; 0 in IDLE.
- Arbitration, both req in the same IDLE cycle: D wins (fixed priority). The losing req stays pending.
- Requester may change addr/req after its gnt; the captured copy is used.
- Read-after-write to the same address returns the new value; the store commits in its RESP cycle.
- ld_en honoured only in IDLE. It writes ld_data at ld_addr that edge and suppresses both grants that cycle. ld_en outside IDLE is ignored.
- Reset mid-operation (WAIT/RESP): transaction dropped, no rvalid, pending store not committed, FSM=IDLE.
- Address is always in range (ADDR_W-sized); no wrap handling needed.

Optional Feature:
- RR_ARB_EN defined: round-robin arbitration.
  - On simultaneous requests, the port not served by the last grant wins.
  - Pointer updates on every grant; reset value favours D first.
- RR_ARB_EN undefined: fixed priority, D over IF. The pointer logic is absent.

Decomposition:
- Shared package pipe_32_pkg holds:
  - mem_state_t enum (IDLE, WAIT, RESP);
  - port_id_t enum (PORT_IF, PORT_D);
  - default ADDR_W/DATA_W constants;
  - WAIT_CYC legality bound (7).
- One sub-module, mem_arbiter_32: combinational grant select from if_req, d_req, idle, ld_en and pointer state. It contains the RR_ARB_EN pointer register when enabled.

Test Plan (WAIT_CYC=1 unless stated):
- Backdoor: ld_en writes 0x2800000A at addr 5. Then IF read addr 5 -> if_gnt at cycle N, if_rvalid at N+2 with if_rdata=0x2800000A.
- Store/load: D store 0xDEADBEEF to 20, then D load 20 -> d_rvalid/d_rdata=0 on the store ack, then 0xDEADBEEF. IF never pulses.
- Contention, fixed priority: IF and D both request in the same cycle -> d_gnt first; if_gnt at grant+3; responses in that order.
  - With RR_ARB_EN, two consecutive contentions -> D then IF.
- Wait states: WAIT_CYC=0 -> rvalid at grant+1. WAIT_CYC=7 -> rvalid at grant+8. busy high exactly during the gap.
- Reset mid-store: assert rst_n=0 in WAIT of a store of 0x1234 to addr 9 (addr 9 preloaded 0x55) -> no d_rvalid; later load 9 returns 0x55.
- ld_en during WAIT: ld to addr 3 is ignored, prior contents retained. ld_en in IDLE while if_req=1 -> ld commits, if_gnt=0 that cycle, granted next cycle.
